// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
// Purpose : bundles the word-load handshake and the serial output bus of the
//           piso_serializer into one interface. Signal names are kept from the
//           serializer's point of view (_i = into the serializer, _o = out).
// Ports   : none (parameter WIDTH sizes the parallel word)
//   load_valid_i  upstream word valid
//   load_data_i   upstream word, sampled on handshake
//   load_ready_o  serializer can accept a word this cycle
//   ser_o         serial data bit
//   ser_valid_o   ser_o carries a valid bit this cycle
//   ser_last_o    final bit of the current frame
//   busy_o        frame in progress
// Modports: master = word source / serial sink (environment side)
//           slave  = the serializer itself
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
  parameter int WIDTH = 8
);

  logic             load_valid_i;
  logic [WIDTH-1:0] load_data_i;
  logic             load_ready_o;
  logic             ser_o;
  logic             ser_valid_o;
  logic             ser_last_o;
  logic             busy_o;

  modport master (
    output load_valid_i,
    output load_data_i,
    input  load_ready_o,
    input  ser_o,
    input  ser_valid_o,
    input  ser_last_o,
    input  busy_o
  );

  modport slave (
    input  load_valid_i,
    input  load_data_i,
    output load_ready_o,
    output ser_o,
    output ser_valid_o,
    output ser_last_o,
    output busy_o
  );

endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Purpose : parallel-in / serial-out transmitter. Accepts a WIDTH-bit word on
//           a valid/ready handshake and sends it LSB first, one bit per clk,
//           with fully registered serial outputs and zero-gap back-to-back
//           frames.
// Parameters:
//   WIDTH   data word width in bits (2..32)
// Ports:
//   clk     rising-edge clock, the only clock
//   reset   synchronous, active-high reset
//   bus     piso_serializer_if.slave (load handshake + serial outputs)
// Build option:
//   PISO_PARITY_EN  when defined, an even-parity bit (XOR of the accepted
//                   word) follows data bit WIDTH-1 and carries ser_last_o.
//                   When undefined no parity logic exists and a frame is
//                   exactly WIDTH bits.
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  piso_serializer_if.slave bus
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]           r_state;
  logic [FRAME_LEN-1:0] r_shift;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ser;
  logic                 r_ser_valid;
  logic                 r_ser_last;

  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_load_ready;
  logic                 w_accept;

  // The whole frame is built at accept time, so parity always reflects the
  // word that was actually handed over.
`ifdef PISO_PARITY_EN
  assign w_frame = {^bus.load_data_i, bus.load_data_i};
`else
  assign w_frame = bus.load_data_i;
`endif

  // Ready during the last-bit cycle is what allows a new word to follow
  // with no bubble; reset masks ready so nothing is accepted on a reset edge.
  assign w_load_ready = !reset &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_SHIFT) && r_ser_last));
  assign w_accept     = bus.load_valid_i && w_load_ready;

  // Bit 0 is registered directly onto ser_o at the accept edge; the shift
  // register holds only the remaining bits. r_count tracks the index of the
  // bit currently on ser_o and stops at LAST_CNT, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_ser       <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_SHIFT;
      r_shift     <= w_frame >> 1;
      r_count     <= '0;
      r_ser       <= w_frame[0];
      r_ser_valid <= 1'b1;
      r_ser_last  <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      if (r_ser_last) begin
        r_state     <= ST_IDLE;
        r_ser       <= 1'b0;
        r_ser_valid <= 1'b0;
        r_ser_last  <= 1'b0;
      end else begin
        r_shift     <= r_shift >> 1;
        r_ser       <= r_shift[0];
        r_count     <= r_count + CNT_W'(1);
        r_ser_last  <= ((r_count + CNT_W'(1)) == LAST_CNT);
      end
    end
  end

  assign bus.load_ready_o = w_load_ready;
  assign bus.ser_o        = r_ser;
  assign bus.ser_valid_o  = r_ser_valid;
  assign bus.ser_last_o   = r_ser_last;
  assign bus.busy_o       = r_ser_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Purpose : directed, self-checking bench for piso_serializer (WIDTH=8).
//           Covers reset, a single word, back-to-back words, backpressure,
//           reset mid-frame and, when PISO_PARITY_EN is defined, the parity
//           bit. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  piso_serializer_if #(.WIDTH(8)) bus ();

  piso_serializer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held for three edges with a word offered the whole time.
  task automatic test_reset();
    reset            = 1'b1;
    bus.load_valid_i = 1'b1;
    bus.load_data_i  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({bus.load_ready_o, bus.ser_o, bus.ser_valid_o, bus.ser_last_o, bus.busy_o} !== 5'b00000) begin
        miscompares++;
        $display("[TB] FAIL reset edge %0d: got ready/ser/valid/last/busy=%b, expected 00000", i,
                 {bus.load_ready_o, bus.ser_o, bus.ser_valid_o, bus.ser_last_o, bus.busy_o});
      end
    end
    reset            = 1'b0;
    bus.load_valid_i = 1'b0;
    #1;
    vectors++;
    if (bus.load_ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release ready: got %b, expected 1", bus.load_ready_o);
    end
    step();
    vectors++;
    if ({bus.ser_valid_o, bus.busy_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_no_accept: got valid/busy=%b, expected 00", {bus.ser_valid_o, bus.busy_o});
    end
  endtask

  // One word 8'hA5, LSB first: 1,0,1,0,0,1,0,1 (parity 0 when enabled).
  task automatic test_single_word();
    logic [8:0] exp;
    exp = 9'h0A5;
    bus.load_data_i  = 8'hA5;
    bus.load_valid_i = 1'b1;
    vectors++;
    if (bus.load_ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_ready_idle: got %b, expected 1", bus.load_ready_o);
    end
    step();
    bus.load_valid_i = 1'b0;
    bus.load_data_i  = 8'h00;
    for (int k = 0; k < FLEN; k++) begin
      vectors++;
      if ({bus.load_ready_o, bus.ser_valid_o, bus.busy_o, bus.ser_o, bus.ser_last_o} !==
          {(k == FLEN-1), 1'b1, 1'b1, exp[k], (k == FLEN-1)}) begin
        miscompares++;
        $display("[TB] FAIL single_word bit %0d: got ready/valid/busy/ser/last=%b, expected %b", k,
                 {bus.load_ready_o, bus.ser_valid_o, bus.busy_o, bus.ser_o, bus.ser_last_o},
                 {(k == FLEN-1), 1'b1, 1'b1, exp[k], (k == FLEN-1)});
      end
      step();
    end
    vectors++;
    if ({bus.load_ready_o, bus.ser_valid_o, bus.busy_o, bus.ser_o, bus.ser_last_o} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL single_word_end: got ready/valid/busy/ser/last=%b, expected 10000",
               {bus.load_ready_o, bus.ser_valid_o, bus.busy_o, bus.ser_o, bus.ser_last_o});
    end
  endtask

  // 8'hFF then 8'h00, second word held valid from the cycle after the first accept.
  task automatic test_back_to_back();
    logic [8:0] exp0;
    logic [8:0] exp1;
    int         b;
    logic       e;
    exp0 = 9'h0FF;
    exp1 = 9'h000;
    bus.load_data_i  = 8'hFF;
    bus.load_valid_i = 1'b1;
    step();
    bus.load_data_i  = 8'h00;
    for (int k = 0; k < 2*FLEN; k++) begin
      b = k % FLEN;
      e = (k < FLEN) ? exp0[b] : exp1[b];
      vectors++;
      if ({bus.load_ready_o, bus.ser_valid_o, bus.ser_o, bus.ser_last_o} !==
          {(b == FLEN-1), 1'b1, e, (b == FLEN-1)}) begin
        miscompares++;
        $display("[TB] FAIL back_to_back bit %0d: got ready/valid/ser/last=%b, expected %b", k,
                 {bus.load_ready_o, bus.ser_valid_o, bus.ser_o, bus.ser_last_o},
                 {(b == FLEN-1), 1'b1, e, (b == FLEN-1)});
      end
      step();
      if (k == FLEN-1) bus.load_valid_i = 1'b0;
    end
    vectors++;
    if ({bus.ser_valid_o, bus.ser_last_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_end: got valid/last=%b, expected 00", {bus.ser_valid_o, bus.ser_last_o});
    end
  endtask

  // 8'h96 in flight, 8'h3C offered from bit 3 onward; must wait for the last bit.
  task automatic test_backpressure();
    logic [8:0] exp0;
    logic [8:0] exp1;
    int         b;
    logic       e;
    exp0 = 9'h096;
    exp1 = 9'h03C;
    bus.load_data_i  = 8'h96;
    bus.load_valid_i = 1'b1;
    step();
    bus.load_valid_i = 1'b0;
    bus.load_data_i  = 8'h00;
    for (int k = 0; k < 2*FLEN; k++) begin
      b = k % FLEN;
      e = (k < FLEN) ? exp0[b] : exp1[b];
      vectors++;
      if ({bus.load_ready_o, bus.ser_valid_o, bus.ser_o, bus.ser_last_o} !==
          {(b == FLEN-1), 1'b1, e, (b == FLEN-1)}) begin
        miscompares++;
        $display("[TB] FAIL backpressure bit %0d: got ready/valid/ser/last=%b, expected %b", k,
                 {bus.load_ready_o, bus.ser_valid_o, bus.ser_o, bus.ser_last_o},
                 {(b == FLEN-1), 1'b1, e, (b == FLEN-1)});
      end
      step();
      if (k == 2) begin
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 8'h3C;
      end
      if (k == FLEN-1) begin
        bus.load_valid_i = 1'b0;
        bus.load_data_i  = 8'h00;
      end
    end
    vectors++;
    if ({bus.ser_valid_o, bus.ser_last_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL backpressure_end: got valid/last=%b, expected 00", {bus.ser_valid_o, bus.ser_last_o});
    end
  endtask

  // 8'h81 aborted by reset while bit 3 is on ser_o, then 8'h5A sent cleanly.
  task automatic test_reset_mid_frame();
    logic [8:0] exp0;
    logic [8:0] exp1;
    exp0 = 9'h081;
    exp1 = 9'h05A;
    bus.load_data_i  = 8'h81;
    bus.load_valid_i = 1'b1;
    step();
    bus.load_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({bus.ser_valid_o, bus.ser_o, bus.ser_last_o} !== {1'b1, exp0[k], 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL abort_pre bit %0d: got valid/ser/last=%b, expected %b", k,
                 {bus.ser_valid_o, bus.ser_o, bus.ser_last_o}, {1'b1, exp0[k], 1'b0});
      end
      if (k < 3) step();
    end
    reset            = 1'b1;
    bus.load_valid_i = 1'b1;
    bus.load_data_i  = 8'h55;
    #1;
    vectors++;
    if (bus.load_ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_ready_in_reset: got %b, expected 0", bus.load_ready_o);
    end
    step();
    vectors++;
    if ({bus.ser_valid_o, bus.ser_o, bus.ser_last_o, bus.busy_o} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs: got valid/ser/last/busy=%b, expected 0000",
               {bus.ser_valid_o, bus.ser_o, bus.ser_last_o, bus.busy_o});
    end
    reset            = 1'b0;
    bus.load_valid_i = 1'b0;
    step();
    vectors++;
    if ({bus.load_ready_o, bus.ser_valid_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL abort_no_accept: got ready/valid=%b, expected 10", {bus.load_ready_o, bus.ser_valid_o});
    end
    bus.load_data_i  = 8'h5A;
    bus.load_valid_i = 1'b1;
    step();
    bus.load_valid_i = 1'b0;
    for (int k = 0; k < FLEN; k++) begin
      vectors++;
      if ({bus.ser_valid_o, bus.ser_o, bus.ser_last_o} !== {1'b1, exp1[k], (k == FLEN-1)}) begin
        miscompares++;
        $display("[TB] FAIL abort_next_word bit %0d: got valid/ser/last=%b, expected %b", k,
                 {bus.ser_valid_o, bus.ser_o, bus.ser_last_o}, {1'b1, exp1[k], (k == FLEN-1)});
      end
      step();
    end
    vectors++;
    if (bus.ser_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_next_end: got valid=%b, expected 0", bus.ser_valid_o);
    end
  endtask

`ifdef PISO_PARITY_EN
  // 8'h07 -> 1,1,1,0,0,0,0,0,1 ; 8'h03 -> parity bit 0.
  task automatic test_parity();
    logic [7:0] words [2];
    logic [8:0] exps  [2];
    words[0] = 8'h07;  exps[0] = 9'h107;
    words[1] = 8'h03;  exps[1] = 9'h003;
    for (int w = 0; w < 2; w++) begin
      bus.load_data_i  = words[w];
      bus.load_valid_i = 1'b1;
      step();
      bus.load_valid_i = 1'b0;
      for (int k = 0; k < 9; k++) begin
        vectors++;
        if ({bus.ser_valid_o, bus.ser_o, bus.ser_last_o} !== {1'b1, exps[w][k], (k == 8)}) begin
          miscompares++;
          $display("[TB] FAIL parity word %0d bit %0d: got valid/ser/last=%b, expected %b", w, k,
                   {bus.ser_valid_o, bus.ser_o, bus.ser_last_o}, {1'b1, exps[w][k], (k == 8)});
        end
        step();
      end
      vectors++;
      if (bus.ser_valid_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL parity_end word %0d: got valid=%b, expected 0", w, bus.ser_valid_o);
      end
    end
  endtask
`endif

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    bus.load_valid_i = 1'b0;
    bus.load_data_i  = 8'h00;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
